// File: rtl/audio_pkg.sv
// Shared types and arithmetic for the codec unit's sample path: default widths,
// the stereo sample record, the feeder controller states and the gain/saturate step.
package audio_pkg;

  localparam int unsigned AUDIO_SAMPLE_W = 24;
  localparam int unsigned AUDIO_GAIN_W   = 16;

  typedef struct packed {
    logic signed [AUDIO_SAMPLE_W-1:0] l;
    logic signed [AUDIO_SAMPLE_W-1:0] r;
  } stereo_sample_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} feeder_state_e;

  // x * gain in Q1.(gw-1), floor shift, clamp to a signed sw-bit range.
  // Widths are constants at every call site, so the shifts fold away.
  function automatic logic signed [63:0] sat_scale(input logic signed [31:0] x,
                                                   input logic [31:0]        g,
                                                   input int unsigned        sw,
                                                   input int unsigned        gw);
    logic signed [63:0] p, y, hi, lo;
    p  = $signed({{32{x[31]}}, x}) * $signed({32'd0, g});
    y  = p >>> (gw - 1);
    hi = (64'sd1 <<< (sw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (sw - 1));
    if (y > hi)      sat_scale = hi;
    else if (y < lo) sat_scale = lo;
    else             sat_scale = y;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// Head entry is visible on data_o whenever valid_o is high; data_o reads zero when empty.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]                 wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic                        empty, full, do_push, do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty;
  assign wptr_d  = wptr_q + (AW+1)'(do_push);
  assign rptr_d  = rptr_q + (AW+1)'(do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

  assign valid_o = ~empty;
  assign data_o  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign level_o = wptr_q - rptr_q;

endmodule

// File: rtl/audio_sample_feeder.sv
// Gain/saturate stage feeding packed L/R beats to the codec AXI4-Stream slave.
// Intake is credit-gated so the 2-stage pipeline never stalls; underruns are counted in RUN.
module audio_sample_feeder
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = AUDIO_SAMPLE_W,
  parameter int unsigned GAIN_W     = AUDIO_GAIN_W,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          axis_aclk,
  input  logic                          axis_aresetn,
  input  logic                          enable,
  input  logic [GAIN_W-1:0]             gain,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SAMPLE_W-1:0]           in_left,
  input  logic [SAMPLE_W-1:0]           in_right,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [63:0]                   m_axis_tdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   underrun_count,
  input  logic                          clear_underrun
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  feeder_state_e               state_q, state_d;
  logic                        in_ready_q, in_ready_d;
  logic [2:1]                  vld_pipe_q;
  logic signed [SAMPLE_W-1:0]  s1_l_q, s1_r_q, s2_l_q, s2_r_q;
  logic [GAIN_W-1:0]           s1_g_q;
  logic [31:0]                 urun_q, urun_d;
  logic                        accept, push, pop;
  logic [LW:0]                 committed_d;
  logic [63:0]                 s2_word;

  assign accept = in_valid & in_ready_q;
  assign push   = vld_pipe_q[2];
  assign pop    = m_axis_tvalid & m_axis_tready;

  // Slots owned after this edge: FIFO entries plus beats still in the pipeline.
  // Keeping this below depth reserves a slot for a beat accepted next cycle.
  assign committed_d = (LW+1)'(fifo_level) + (LW+1)'(push) - (LW+1)'(pop)
                     + (LW+1)'(accept) + (LW+1)'(vld_pipe_q[1]);
  assign in_ready_d  = enable && (committed_d < (LW+1)'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)                                           state_d = RUN;
        else if (vld_pipe_q == '0 && !m_axis_tvalid)          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    urun_d = urun_q;
    if (clear_underrun)
      urun_d = '0;
    else if (m_axis_tready && !m_axis_tvalid && enable && state_q == RUN && urun_q != '1)
      urun_d = urun_q + 32'd1;
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      vld_pipe_q <= '0;
      s1_l_q     <= '0;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s2_l_q     <= '0;
      s2_r_q     <= '0;
      urun_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      vld_pipe_q <= {vld_pipe_q[1], accept};
      urun_q     <= urun_d;
      if (accept) begin
        s1_l_q <= in_left;
        s1_r_q <= in_right;
        s1_g_q <= gain;
      end
      if (vld_pipe_q[1]) begin
        s2_l_q <= SAMPLE_W'(sat_scale(32'(s1_l_q), 32'(s1_g_q), SAMPLE_W, GAIN_W));
        s2_r_q <= SAMPLE_W'(sat_scale(32'(s1_r_q), 32'(s1_g_q), SAMPLE_W, GAIN_W));
      end
    end
  end

  assign s2_word = {{(32-SAMPLE_W){s2_l_q[SAMPLE_W-1]}}, s2_l_q,
                    {(32-SAMPLE_W){s2_r_q[SAMPLE_W-1]}}, s2_r_q};

  sync_fifo_fwft #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (axis_aclk),
    .rst_n   (axis_aresetn),
    .push_i  (push),
    .data_i  (s2_word),
    .pop_i   (pop),
    .valid_o (m_axis_tvalid),
    .data_o  (m_axis_tdata),
    .level_o (fifo_level)
  );

  assign in_ready       = in_ready_q;
  assign underrun_count = urun_q;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Self-checking bench for audio_sample_feeder: vector table through a scoreboard,
// plus latency, backpressure, underrun, drain and mid-burst reset sequences.
module tb_audio_sample_feeder;
  import audio_pkg::*;

  logic        clk, rst_n, enable, in_valid, in_ready, tready, tvalid, clear_underrun;
  logic [15:0] gain;
  logic [23:0] in_left, in_right;
  logic [63:0] tdata;
  logic [3:0]  level;
  logic [31:0] ucount;

  audio_sample_feeder dut (
    .axis_aclk      (clk),
    .axis_aresetn   (rst_n),
    .enable         (enable),
    .gain           (gain),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_left        (in_left),
    .in_right       (in_right),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tdata   (tdata),
    .fifo_level     (level),
    .underrun_count (ucount),
    .clear_underrun (clear_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    stereo_sample_t s;
    logic [15:0]    g;
    logic [63:0]    exp;
  } vec_t;

  vec_t        vecs[8];
  logic [63:0] exp_q[$];
  logic [63:0] cur_exp;
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [63:0] pack(input logic [23:0] l, input logic [23:0] r);
    return {{8{l[23]}}, l, {8{r[23]}}, r};
  endfunction

  task automatic setv(input int i, input logic [23:0] l, input logic [23:0] r,
                      input logic [15:0] g, input logic [63:0] exp);
    vecs[i].s.l = l;
    vecs[i].s.r = r;
    vecs[i].g   = g;
    vecs[i].exp = exp;
  endtask

  // Scoreboard: record accepted beats, compare emitted beats in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got %h want none", tdata);
        end else begin
          chk("beat_data", tdata, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r, input logic [15:0] g,
                      input logic [63:0] exp);
    bit done = 0;
    in_left = l; in_right = r; gain = g; cur_exp = exp; in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    if (!done) chk("send_timeout", 64'(done), 64'd1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    bit ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tvalid) ok = 1;
    end
    chk(nm, 64'(ok), 64'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int          k, acc;
    logic [31:0] saved;
    logic [23:0] bl, br;
    bit          idle_seen;

    setv(0, 24'h123456, 24'hFEDCBA, 16'h8000, 64'h0012_3456_FFFE_DCBA);
    setv(1, 24'h7FFFFF, 24'h800000, 16'hFFFF, 64'h007F_FFFF_FF80_0000);
    setv(2, 24'h000003, 24'hFFFFFD, 16'h4000, 64'h0000_0001_FFFF_FFFE);
    setv(3, 24'h7FFFFF, 24'h800000, 16'h0000, 64'h0000_0000_0000_0000);
    setv(4, 24'h800000, 24'h7FFFFF, 16'h8000, 64'hFF80_0000_007F_FFFF);
    setv(5, 24'h100000, 24'hF00000, 16'hC000, 64'h0018_0000_FFE8_0000);
    setv(6, 24'h000001, 24'hFFFFFF, 16'h0001, 64'h0000_0000_FFFF_FFFF);
    setv(7, 24'h400000, 24'hC00000, 16'hFFFF, 64'h007F_FF80_FF80_0080);

    rst_n = 1'b1; enable = 0; in_valid = 0; tready = 0; clear_underrun = 0;
    gain = 0; in_left = 0; in_right = 0; cur_exp = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_tvalid",   64'(tvalid),   64'd0);
    chk("rst_tdata",    tdata,         64'd0);
    chk("rst_level",    64'(level),    64'd0);
    chk("rst_underrun", 64'(ucount),   64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Latency: beat visible on the 3rd cycle after the accepting cycle.
    enable = 1; tready = 1;
    tick(); tick();
    send(vecs[0].s.l, vecs[0].s.r, vecs[0].g, vecs[0].exp);
    @(negedge clk); chk("lat_c1_tvalid", 64'(tvalid), 64'd0);
    @(negedge clk); chk("lat_c2_tvalid", 64'(tvalid), 64'd0);
    @(negedge clk); chk("lat_c3_tvalid", 64'(tvalid), 64'd1);
    chk("lat_c3_tdata", tdata, vecs[0].exp);
    tick();
    wait_drain("lat_drain");

    for (int i = 0; i < 8; i++) send(vecs[i].s.l, vecs[i].s.r, vecs[i].g, vecs[i].exp);
    wait_drain("table_drain");

    // Backpressure: continuous offers with the sink stalled.
    tready = 0; k = 0; acc = 0; in_valid = 1; gain = 16'h8000;
    for (int c = 0; c < 20; c++) begin
      bl = 24'(k + 16);
      br = 24'd0 - 24'(k + 1);
      in_left = bl; in_right = br; cur_exp = pack(bl, br);
      @(negedge clk);
      if (in_ready) begin acc++; k++; end
      tick();
    end
    in_valid = 0;
    chk("bp_accepted", 64'(acc),      64'd8);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_level",    64'(level),    64'd8);
    tready = 1;
    wait_drain("bp_drain");

    // Underrun counting and clear priority.
    tready = 0; clear_underrun = 1;
    tick();
    clear_underrun = 0;
    chk("ur_cleared", 64'(ucount), 64'd0);
    tready = 1;
    repeat (10) @(posedge clk);
    #2 tready = 0;
    chk("ur_count10", 64'(ucount), 64'd10);
    clear_underrun = 1; tready = 1;
    tick();
    clear_underrun = 0; tready = 0;
    chk("ur_clear_prio", 64'(ucount), 64'd0);

    // Drain: fill 5 beats, drop enable, everything still comes out.
    for (int i = 0; i < 5; i++) begin
      bl = 24'(32 + i);
      br = 24'hABC000 + 24'(i);
      send(bl, br, 16'h8000, pack(bl, br));
    end
    repeat (3) tick();
    chk("drain_level5", 64'(level), 64'd5);
    saved = ucount;
    enable = 0;
    tick();
    chk("drain_in_ready", 64'(in_ready), 64'd0);
    tready = 1;
    wait_drain("drain_out");
    idle_seen = 0;
    for (int t = 0; t < 20 && !idle_seen; t++) begin
      @(negedge clk);
      if (dut.state_q == IDLE) idle_seen = 1;
    end
    chk("drain_idle",   64'(idle_seen), 64'd1);
    chk("drain_ucount", 64'(ucount),    64'(saved));
    tick();

    // Asynchronous reset with six beats buffered.
    enable = 1; tready = 0;
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      bl = 24'h050000 + 24'(i);
      send(bl, bl, 16'h8000, pack(bl, bl));
    end
    repeat (3) tick();
    chk("ar_level6", 64'(level), 64'd6);
    rst_n = 0;
    exp_q.delete();
    #1;
    chk("ar_tvalid",   64'(tvalid),   64'd0);
    chk("ar_tdata",    tdata,         64'd0);
    chk("ar_level",    64'(level),    64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd0);
    chk("ar_ucount",   64'(ucount),   64'd0);
    tick(); tick();
    rst_n = 1;
    tick();
    tready = 1;
    tick(); tick();
    send(vecs[5].s.l, vecs[5].s.r, vecs[5].g, vecs[5].exp);
    wait_drain("ar_new_only");
    repeat (5) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
